// File: rtl/music_pkg.sv
// Shared definitions for the buzzer note path: envelope states and note coding.
package music_pkg;

  localparam int NOTE_W    = 6;
  localparam int REST_CODE = 21;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } env_state_t;

endpackage

// File: rtl/env_tick_gen.sv
// Free-running envelope prescaler: one-cycle tick every TICK_DIV clocks.
module env_tick_gen #(
  parameter int TICK_DIV = 25000
) (
  input  logic IN_clk,
  input  logic IN_rst_n,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge IN_clk) begin
    if (!IN_rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/music_envelope.sv
// ADSR volume envelope for the buzzer tone, applied by gating the tone with a
// fast PWM whose duty follows the envelope level.
module music_envelope
  import music_pkg::*;
#(
  parameter int CLK_HZ       = 25000000,
  parameter int TICK_DIV     = CLK_HZ / 1000,
  parameter int ATTACK_STEP  = 32,
  parameter int DECAY_STEP   = 2,
  parameter int RELEASE_STEP = 8,
  parameter int SUSTAIN_LVL  = 96,
  parameter int REST_CODE    = music_pkg::REST_CODE
) (
  input  logic              IN_clk,
  input  logic              IN_rst_n,
  input  logic              IN_tone,
  input  logic [NOTE_W-1:0] IN_note,
  input  logic              IN_enable,
  output logic              OUT_audio,
  output logic [7:0]        OUT_level,
  output logic              OUT_busy
);

  localparam logic [8:0]        ATT9 = 9'(ATTACK_STEP);
  localparam logic [8:0]        DEC9 = 9'(DECAY_STEP);
  localparam logic [8:0]        REL9 = 9'(RELEASE_STEP);
  localparam logic [8:0]        SUS9 = 9'(SUSTAIN_LVL);
  localparam logic [NOTE_W-1:0] REST = NOTE_W'(REST_CODE);

  env_state_t        state, next_state;
  logic [7:0]        level, next_level;
  logic [NOTE_W-1:0] note_q;
  logic [7:0]        pwm_cnt;
  logic              audio_q;
  logic              tick;
  logic              trigger, release_req;
  logic [8:0]        up, down_dec, down_rel;

  env_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .IN_clk  (IN_clk),
    .IN_rst_n(IN_rst_n),
    .tick    (tick)
  );

  always_ff @(posedge IN_clk) begin
    if (!IN_rst_n) begin
      state   <= IDLE;
      level   <= 8'd0;
      note_q  <= REST;
      pwm_cnt <= 8'd0;
      audio_q <= 1'b0;
    end else begin
      state   <= next_state;
      level   <= next_level;
      note_q  <= IN_note;
      pwm_cnt <= pwm_cnt + 8'd1;
      audio_q <= IN_tone & (pwm_cnt < level);
    end
  end

  // Level steps only on ticks; note events override the envelope's own progression.
  always_comb begin
    next_state  = state;
    next_level  = level;
    trigger     = IN_enable && (IN_note != note_q) && (IN_note != REST);
    release_req = ((state == ATTACK) || (state == DECAY) || (state == SUSTAIN)) &&
                  (!IN_enable || (IN_note == REST));
    up       = {1'b0, level} + ATT9;
    down_dec = {1'b0, level} - DEC9;
    down_rel = {1'b0, level} - REL9;

    if (tick) begin
      case (state)
        IDLE: next_level = 8'd0;
        ATTACK: begin
          if (up >= 9'd255) begin
            next_level = 8'd255;
            next_state = DECAY;
          end else begin
            next_level = up[7:0];
          end
        end
        DECAY: begin
          if (down_dec[8] || (down_dec <= SUS9)) begin
            next_level = SUS9[7:0];
            next_state = SUSTAIN;
          end else begin
            next_level = down_dec[7:0];
          end
        end
        RELEASE: begin
          if (down_rel[8] || (down_rel == 9'd0)) begin
            next_level = 8'd0;
            next_state = IDLE;
          end else begin
            next_level = down_rel[7:0];
          end
        end
        default: next_level = level;
      endcase
    end

    if (trigger) begin
      next_state = ATTACK;
    end else if (release_req) begin
      next_state = RELEASE;
    end
  end

  assign OUT_audio = audio_q;
  assign OUT_level = level;
  assign OUT_busy  = (state != IDLE);

endmodule

// File: doc/music_envelope.md
# music_envelope

Downstream articulation stage for the buzzer tone generator. It consumes the generator's square-wave tone and current note index, and applies a per-note attack/decay/sustain/release volume envelope via high-rate PWM gating. It drives the buzzer pin in place of the raw tone, so consecutive notes are audibly separated and rests fade instead of clicking.

## Interface
- CLK_HZ, 25000000, system clock frequency (documentation/derivation only)
- TICK_DIV, 25000, IN_clk cycles per envelope tick (1 kHz at 25 MHz)
- ATTACK_STEP, 32, level increment per tick in ATTACK
- DECAY_STEP, 2, level decrement per tick in DECAY
- RELEASE_STEP, 8, level decrement per tick in RELEASE
- SUSTAIN_LVL, 96, hold level in SUSTAIN
- REST_CODE, 21, note index meaning silence
- IN_clk  input  1  system clock, 25 MHz
- IN_rst_n  input  1  reset; one clock, reset synchronous and active-low
- IN_tone  input  1  square-wave tone from generator, IN_clk domain
- IN_note  input  6  current note index (0..20 tone, 21 rest)
- IN_enable  input  1  high = envelope may sound; low forces release
- OUT_audio  output  1  PWM-gated tone to buzzer
- OUT_level  output  8  current envelope level
- OUT_busy  output  1  high whenever state != IDLE

## Operation
- Reset: state IDLE, level 0, note_q = REST_CODE, prescaler 0, pwm_cnt 0, OUT_audio 0, OUT_level 0, OUT_busy 0.
- note_q registers IN_note every cycle. Trigger = IN_enable & (IN_note != note_q) & (IN_note != REST_CODE). An unchanged note is legato and does not retrigger.
- Release request = IN_enable low, or IN_note == REST_CODE, while state is ATTACK/DECAY/SUSTAIN.
- States:
  - IDLE: level held at 0. Trigger -> ATTACK.
  - ATTACK: each tick, level = min(level+ATTACK_STEP, 255). When level reaches 255 -> DECAY.
  - DECAY: each tick, level = max(level-DECAY_STEP, SUSTAIN_LVL). When level reaches SUSTAIN_LVL -> SUSTAIN.
  - SUSTAIN: level held.
  - RELEASE: each tick, level = max(level-RELEASE_STEP, 0). When level reaches 0 -> IDLE.
- Trigger from any state -> ATTACK, with no level reset. Attack continues from the current level.
- Trigger and release request in the same cycle: trigger wins.
- IN_enable low in IDLE: remain IDLE. Triggers are ignored while IN_enable is low.
- Arithmetic is 9-bit internally and clamped to 8 bits. No wrap-around.
- PWM: pwm_cnt is a free-running 8-bit counter (97.66 kHz frame). Gate = pwm_cnt < level. Level 0 gives a permanently low output; level 255 gives 255/256 duty.
- OUT_audio = registered (IN_tone & gate).

## Timing
- Prescaler is free-running from reset, counting 0..TICK_DIV-1. Tick is a 1-cycle pulse on wrap, and is not realigned on trigger.
- State change on trigger or release: registered, visible in the cycle after IN_note changes (1-cycle latency relative to note_q).
- Level changes only on tick cycles. A state entered on a tick cycle begins stepping on the next tick.
- OUT_audio: 1-cycle latency from IN_tone and level.
- OUT_level and OUT_busy are registered and update in the same cycle as the level and state.
- Synchronous reset mid-envelope: all outputs 0 on the next edge. After reset, a held non-rest IN_note retriggers, because note_q resets to REST_CODE.

## Structure
- Shared package music_pkg holds:
  - env_state_t enum: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
  - REST_CODE and NOTE_W = 6, shared with the tone generator.
- Sub-module env_tick_gen: prescaler with TICK_DIV parameter and tick output. The rest of the logic is a single module.

## Test plan
All scenarios use TICK_DIV = 4.
- Reset held 3 cycles with IN_note = 7 -> OUT_audio/OUT_level/OUT_busy all 0. After release of reset, ATTACK is entered next cycle.
- IN_note 21 -> 7, IN_tone = 1 -> level 32, 64, …, 224, 255 over 8 ticks. Then DECAY reaches 96 after 80 ticks, then SUSTAIN holds 96.
- In SUSTAIN (level 96), IN_tone = 1 -> OUT_audio high exactly 96 of every 256 cycles.
- IN_note -> 21 in SUSTAIN -> RELEASE 96→0 in 12 ticks, then IDLE with OUT_busy 0. IN_note 7 held for 20 ticks -> no retrigger.
- IN_enable low mid-DECAY at level 200 -> RELEASE from 200. A note change with IN_enable low is ignored.
- IN_note 7 -> 9 during RELEASE at level 40 -> ATTACK from 40 (72, 104, …). A simultaneous note change with IN_enable falling -> no trigger, RELEASE.
